nibble_sequencer: RTL and testbench

- Control unit for the 4-bit accumulator/ALU datapath (`operacion`).
- Fetches 8-bit instruction bytes from a program memory and decodes them.
- Drives the datapath's control inputs: `enable_acu`, `enabled_tri_1`, `enabled_tri_2`, `selector`, immediate operand.
- Consumes the datapath's `flags` for conditional jumps; it is the initiator end of the datapath's control interface.

---
 rtl/nibble_sequencer.sv | 161 ++++++++++++++++
 tb/tb_nibble_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_sequencer.sv
// -----------------------------------------------------------------------------
// nibble_sequencer
// Control unit for the 4-bit accumulator/ALU datapath. Fetches one 8-bit
// instruction byte per instruction from a combinational program memory, then
// spends exactly one EXEC cycle driving the datapath controls for it.
//
// Ports
//   clock         system clock, all state changes on the rising edge
//   reset         synchronous, active-high reset
//   run           fetch permission, looked at only while in FETCH
//   prog_data     program memory read data for address prog_addr
//   flags         datapath flags, [1] = carry, [0] = zero
//   prog_addr     program memory address, always equal to the PC
//   enable_acu    accumulator load enable
//   enabled_tri_1 drives operand onto the ALU B bus
//   enabled_tri_2 drives the accumulator onto the datapath output
//   selector      ALU function (000 A, 001 A-B, 010 B, 011 A+B, 100 A NAND B)
//   operand       immediate nibble (IR[3:0]) during EXEC, 0 otherwise
//   halted        1 while the sequencer sits in HALT
// -----------------------------------------------------------------------------
module nibble_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 32'd0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [7:0]          prog_data,
  input  logic [1:0]          flags,
  output logic [PC_WIDTH-1:0] prog_addr,
  output logic                enable_acu,
  output logic                enabled_tri_1,
  output logic                enabled_tri_2,
  output logic [2:0]          selector,
  output logic [3:0]          operand,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_HALT  = 2'b10
  } state_t;

  localparam logic [PC_WIDTH-1:0] LP_RESET_PC = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] LP_PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [7:0]          r_ir;
  logic                r_enable_acu;
  logic                r_tri_1;
  logic                r_tri_2;
  logic [2:0]          r_selector;
  logic                r_halted;

  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_is_jump;
  logic                w_taken;

  // Datapath control word {enable_acu, tri_1, tri_2, selector} for an opcode.
  // Jumps, HALT and the unused opcodes leave the datapath idle.
  function automatic logic [5:0] decode_ctl(input logic [3:0] opcode);
    logic [5:0] ctl;
    case (opcode)
      4'h1:    ctl = 6'b110_010;  // LIT   : acc <= B
      4'h2:    ctl = 6'b110_011;  // ADDI  : acc <= A + B
      4'h3:    ctl = 6'b110_001;  // SUBI  : acc <= A - B
      4'h4:    ctl = 6'b110_100;  // NANDI : acc <= A NAND B
      4'h5:    ctl = 6'b001_000;  // OUT   : accumulator to output
      default: ctl = 6'b000_000;
    endcase
    return ctl;
  endfunction

  assign w_pc_inc = r_pc + LP_PC_ONE;
  // The jump target byte sits right after the opcode; during EXEC the PC
  // already points at it, so prog_data carries the target this cycle.
  assign w_target = PC_WIDTH'(prog_data);

  // Jump classification and condition evaluation for the opcode held in IR.
  always_comb begin
    w_is_jump = 1'b0;
    w_taken   = 1'b0;
    case (r_ir[7:4])
      4'h6:    begin w_is_jump = 1'b1; w_taken = 1'b1;      end
      4'h7:    begin w_is_jump = 1'b1; w_taken = flags[1];  end
      4'h8:    begin w_is_jump = 1'b1; w_taken = ~flags[1]; end
      4'h9:    begin w_is_jump = 1'b1; w_taken = flags[0];  end
      4'hA:    begin w_is_jump = 1'b1; w_taken = ~flags[0]; end
      default: begin w_is_jump = 1'b0; w_taken = 1'b0;      end
    endcase
  end

  // Sequencer state machine. Control outputs are loaded on the FETCH->EXEC
  // edge from the byte being fetched, so they are valid for the whole EXEC
  // cycle and cleared on every other transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= LP_RESET_PC;
      r_ir         <= 8'h00;
      r_enable_acu <= 1'b0;
      r_tri_1      <= 1'b0;
      r_tri_2      <= 1'b0;
      r_selector   <= 3'b000;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (run) begin
            r_ir    <= prog_data;
            r_pc    <= w_pc_inc;
            r_state <= S_EXEC;
            {r_enable_acu, r_tri_1, r_tri_2, r_selector} <= decode_ctl(prog_data[7:4]);
          end else begin
            r_state <= S_FETCH;
            {r_enable_acu, r_tri_1, r_tri_2, r_selector} <= 6'b000_000;
          end
          r_halted <= 1'b0;
        end
        S_EXEC: begin
          {r_enable_acu, r_tri_1, r_tri_2, r_selector} <= 6'b000_000;
          if (r_ir[7:4] == 4'hF) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_is_jump) begin
            // Not taken still has to step over the target byte.
            r_pc     <= w_taken ? w_target : w_pc_inc;
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
          end else begin
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
          end
        end
        S_HALT: begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
          {r_enable_acu, r_tri_1, r_tri_2, r_selector} <= 6'b000_000;
        end
        default: begin
          r_state  <= S_FETCH;
          r_halted <= 1'b0;
          {r_enable_acu, r_tri_1, r_tri_2, r_selector} <= 6'b000_000;
        end
      endcase
    end
  end

  assign prog_addr     = r_pc;
  assign enable_acu    = r_enable_acu;
  assign enabled_tri_1 = r_tri_1;
  assign enabled_tri_2 = r_tri_2;
  assign selector      = r_selector;
  assign halted        = r_halted;
  // The immediate is simply the low IR nibble, gated to 0 outside EXEC.
  assign operand       = (r_state == S_EXEC) ? r_ir[3:0] : 4'h0;

endmodule

// File: tb/tb_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nibble_sequencer
// Directed and random program runs against an instruction-level model:
// each instruction is a FETCH cycle followed by an EXEC cycle whose controls
// come from an opcode table and whose next PC follows the jump rules.
// -----------------------------------------------------------------------------
module tb_nibble_sequencer;

  logic       clock;
  logic       reset;
  logic       run;
  logic [7:0] prog_data;
  logic [1:0] flags;
  logic [7:0] prog_addr;
  logic       enable_acu;
  logic       enabled_tri_1;
  logic       enabled_tri_2;
  logic [2:0] selector;
  logic [3:0] operand;
  logic       halted;

  logic [7:0] mem [256];
  logic [5:0] ctl_tab [16];
  logic [7:0] m_pc;
  int         n_vec;
  int         n_err;
  logic       h;

  wire [5:0] w_ctl = {enable_acu, enabled_tri_1, enabled_tri_2, selector};

  assign prog_data = mem[prog_addr];

  nibble_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .prog_data     (prog_data),
    .flags         (flags),
    .prog_addr     (prog_addr),
    .enable_acu    (enable_acu),
    .enabled_tri_1 (enabled_tri_1),
    .enabled_tri_2 (enabled_tri_2),
    .selector      (selector),
    .operand       (operand),
    .halted        (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {2'b00, w_ctl}, 8'h00);
    chk({tag, "_opnd"}, {4'h0, operand}, 8'h00);
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    run   = 1'b1;
    repeat (3) tick;
    chk("rst_pc", prog_addr, 8'h00);
    chk_idle("rst");
    chk("rst_halt", {7'b0, halted}, 8'h00);
    reset = 1'b0;
    m_pc  = 8'h00;
  endtask

  // One instruction: optional stalled FETCH cycles, the FETCH, the EXEC.
  task automatic do_instr(input logic [1:0] fl, input int idle, output logic hit_halt);
    logic [7:0] ib;
    logic [3:0] op;
    logic [7:0] nx;
    logic       taken;
    logic       is_jump;
    for (int i = 0; i < idle; i++) begin
      run   = 1'b0;
      flags = ~fl;
      #1;
      chk("stall_pc", prog_addr, m_pc);
      chk_idle("stall");
      tick;
    end
    run   = 1'b1;
    flags = ~fl;  // wrong flags outside EXEC: must not influence the jump
    #1;
    chk("fetch_pc", prog_addr, m_pc);
    chk_idle("fetch");
    chk("fetch_halt", {7'b0, halted}, 8'h00);
    ib = mem[m_pc];
    op = ib[7:4];
    tick;
    run   = 1'($urandom_range(0, 1));
    flags = fl;
    #1;
    nx = m_pc + 8'd1;
    is_jump = (op >= 4'h6) && (op <= 4'hA);
    chk("exec_ctl", {2'b00, w_ctl}, {2'b00, ctl_tab[op]});
    if (!is_jump) chk("exec_opnd", {4'h0, operand}, {4'h0, ib[3:0]});
    chk("exec_pc", prog_addr, nx);
    chk("exec_halt", {7'b0, halted}, 8'h00);
    case (op)
      4'h6:    taken = 1'b1;
      4'h7:    taken = fl[1];
      4'h8:    taken = ~fl[1];
      4'h9:    taken = fl[0];
      4'hA:    taken = ~fl[0];
      default: taken = 1'b0;
    endcase
    if (is_jump) m_pc = taken ? mem[nx] : nx + 8'd1;
    else         m_pc = nx;
    tick;
    hit_halt = (op == 4'hF);
    if (hit_halt) begin
      for (int i = 0; i < 2; i++) begin
        run = 1'b1;
        #1;
        chk("halt_flag", {7'b0, halted}, 8'h01);
        chk("halt_pc", prog_addr, m_pc);
        chk_idle("halt");
        tick;
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    run   = 1'b0;
    flags = 2'b00;
    m_pc  = 8'h00;
    for (int i = 0; i < 16; i++) ctl_tab[i] = 6'b000_000;
    ctl_tab[1] = 6'b110_010;
    ctl_tab[2] = 6'b110_011;
    ctl_tab[3] = 6'b110_001;
    ctl_tab[4] = 6'b110_100;
    ctl_tab[5] = 6'b001_000;

    // LIT / ADDI (with a 4-cycle run=0 stall) / OUT / HALT
    clear_mem();
    mem[0] = 8'h1A; mem[1] = 8'h23; mem[2] = 8'h50; mem[3] = 8'hF0;
    do_reset();
    do_instr(2'b00, 0, h);
    do_instr(2'b00, 4, h);
    do_instr(2'b00, 0, h);
    do_instr(2'b00, 0, h);
    chk("halt_at_04", prog_addr, 8'h04);

    // JC taken and not taken
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'h10;
    do_reset();
    do_instr(2'b10, 0, h);
    chk("jc_taken", prog_addr, 8'h10);
    do_reset();
    do_instr(2'b00, 0, h);
    chk("jc_not", prog_addr, 8'h02);

    // JZ / JNZ at 0x20 with zero flag set
    clear_mem();
    mem[0] = 8'h60; mem[1] = 8'h20; mem[8'h20] = 8'h90; mem[8'h21] = 8'h40;
    do_reset();
    do_instr(2'b00, 0, h);
    do_instr(2'b01, 0, h);
    chk("jz_taken", prog_addr, 8'h40);
    mem[8'h20] = 8'hA0;
    do_reset();
    do_instr(2'b00, 0, h);
    do_instr(2'b01, 0, h);
    chk("jnz_not", prog_addr, 8'h22);

    // Reset in the middle of EXEC
    clear_mem();
    mem[0] = 8'h1A;
    do_reset();
    tick;
    chk("pre_rst_acu", {7'b0, enable_acu}, 8'h01);
    reset = 1'b1;
    tick;
    chk("mid_rst_acu", {7'b0, enable_acu}, 8'h00);
    chk("mid_rst_pc", prog_addr, 8'h00);
    reset = 1'b0;
    m_pc  = 8'h00;
    do_instr(2'b00, 0, h);

    // JMP at 0xFF reads its target from 0x00 (which itself runs as a NOP)
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h60; mem[2] = 8'hFF; mem[8'hFF] = 8'h60;
    do_reset();
    do_instr(2'b00, 0, h);
    do_instr(2'b00, 0, h);
    chk("jmp_to_ff", prog_addr, 8'hFF);
    do_instr(2'b00, 0, h);
    chk("wrap_jmp", prog_addr, 8'h05);

    // Random programs with random flags and stalls
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      do_reset();
      h = 1'b0;
      for (int k = 0; k < 40 && !h; k++)
        do_instr(2'($urandom_range(0, 3)), $urandom_range(0, 2), h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
